// File: rtl/otter_alu_decode_if.sv
// Handshake bundle between fetch, the ALU decode stage and execute.
// The slave modport is the decode stage; the master modport drives it.
interface otter_alu_decode_if;
    logic [31:0] instr_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [10:0] alu_fun_o;
    logic [31:0] instr_o;
    logic        illegal_o;
    logic        valid_o;
    logic        ready_i;

    modport slave (
        input  instr_i,
        input  valid_i,
        input  flush_i,
        input  ready_i,
        output ready_o,
        output alu_fun_o,
        output instr_o,
        output illegal_o,
        output valid_o
    );

    modport master (
        output instr_i,
        output valid_i,
        output flush_i,
        output ready_i,
        input  ready_o,
        input  alu_fun_o,
        input  instr_o,
        input  illegal_o,
        input  valid_o
    );
endinterface

// File: rtl/otter_alu_decode.sv
// RV32I ALU-control decode stage: one-cycle decode into an output register backed by one skid entry.
// Define OTTER_ALU_DECODE_ILLEGAL_EN to flag illegal encodings; otherwise they decode to ADD.
module otter_alu_decode (
    input  logic               clk_i,
    input  logic               rst_i,
    otter_alu_decode_if.slave  bus
);

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [10:0] FUN_NONE = 11'h000;
    localparam logic [10:0] FUN_ADD  = 11'h001;
    localparam logic [10:0] FUN_SLL  = 11'h002;
    localparam logic [10:0] FUN_SLT  = 11'h004;
    localparam logic [10:0] FUN_SLTU = 11'h008;
    localparam logic [10:0] FUN_XOR  = 11'h010;
    localparam logic [10:0] FUN_SRL  = 11'h020;
    localparam logic [10:0] FUN_OR   = 11'h040;
    localparam logic [10:0] FUN_AND  = 11'h080;
    localparam logic [10:0] FUN_SUB  = 11'h100;
    localparam logic [10:0] FUN_SRA  = 11'h200;
    localparam logic [10:0] FUN_LUI  = 11'h400;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [10:0] raw_fun;
    logic        raw_illegal;
    logic [10:0] dec_fun;
    logic        dec_illegal;

    logic        out_valid, out_valid_next;
    logic [31:0] out_instr, out_instr_next;
    logic [10:0] out_fun, out_fun_next;
    logic        out_illegal, out_illegal_next;
    logic        skid_valid, skid_valid_next;
    logic [31:0] skid_instr, skid_instr_next;
    logic [10:0] skid_fun, skid_fun_next;
    logic        skid_illegal, skid_illegal_next;
    logic        ready_q;

    logic        xfer_in;
    logic        xfer_out;

    assign opcode = bus.instr_i[6:0];
    assign funct3 = bus.instr_i[14:12];
    assign funct7 = bus.instr_i[31:25];

    // Raw decode: every listed opcode ends in 2'b11, so the full 7-bit match also rejects compressed encodings.
    always_comb begin
        raw_fun     = FUN_NONE;
        raw_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO) begin
                    case (funct3)
                        3'b000:  raw_fun = FUN_ADD;
                        3'b001:  raw_fun = FUN_SLL;
                        3'b010:  raw_fun = FUN_SLT;
                        3'b011:  raw_fun = FUN_SLTU;
                        3'b100:  raw_fun = FUN_XOR;
                        3'b101:  raw_fun = FUN_SRL;
                        3'b110:  raw_fun = FUN_OR;
                        default: raw_fun = FUN_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    raw_fun = FUN_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    raw_fun = FUN_SRA;
                end else begin
                    raw_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: raw_fun = FUN_ADD;
                    3'b001: begin
                        if (funct7 == F7_ZERO) raw_fun = FUN_SLL;
                        else                   raw_illegal = 1'b1;
                    end
                    3'b010: raw_fun = FUN_SLT;
                    3'b011: raw_fun = FUN_SLTU;
                    3'b100: raw_fun = FUN_XOR;
                    3'b101: begin
                        if (funct7 == F7_ZERO)     raw_fun = FUN_SRL;
                        else if (funct7 == F7_ALT) raw_fun = FUN_SRA;
                        else                       raw_illegal = 1'b1;
                    end
                    3'b110:  raw_fun = FUN_OR;
                    default: raw_fun = FUN_AND;
                endcase
            end
            OPC_LUI:                                   raw_fun = FUN_LUI;
            OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_STORE:                       raw_fun = FUN_ADD;
            OPC_BRANCH, OPC_MISCMEM, OPC_SYSTEM:       raw_fun = FUN_NONE;
            default:                                   raw_illegal = 1'b1;
        endcase
    end

`ifdef OTTER_ALU_DECODE_ILLEGAL_EN
    always_comb begin
        dec_fun     = raw_illegal ? FUN_NONE : raw_fun;
        dec_illegal = raw_illegal;
    end
`else
    // Without illegal reporting the flag never leaves this stage; bad encodings fall back to ADD.
    always_comb begin
        dec_fun     = raw_illegal ? FUN_ADD : raw_fun;
        dec_illegal = 1'b0;
    end
`endif

    assign xfer_in  = bus.valid_i && ready_q;
    assign xfer_out = out_valid && bus.ready_i;

    // Skid full implies output full; while the skid is occupied ready_o is low, so nothing new arrives.
    always_comb begin
        out_valid_next    = out_valid;
        out_instr_next    = out_instr;
        out_fun_next      = out_fun;
        out_illegal_next  = out_illegal;
        skid_valid_next   = skid_valid;
        skid_instr_next   = skid_instr;
        skid_fun_next     = skid_fun;
        skid_illegal_next = skid_illegal;

        if (bus.flush_i) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (skid_valid) begin
            if (xfer_out) begin
                out_instr_next   = skid_instr;
                out_fun_next     = skid_fun;
                out_illegal_next = skid_illegal;
                skid_valid_next  = 1'b0;
            end
        end else if (!out_valid || xfer_out) begin
            out_valid_next = xfer_in;
            if (xfer_in) begin
                out_instr_next   = bus.instr_i;
                out_fun_next     = dec_fun;
                out_illegal_next = dec_illegal;
            end
        end else if (xfer_in) begin
            skid_valid_next   = 1'b1;
            skid_instr_next   = bus.instr_i;
            skid_fun_next     = dec_fun;
            skid_illegal_next = dec_illegal;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid    <= 1'b0;
            out_instr    <= 32'h0;
            out_fun      <= FUN_NONE;
            out_illegal  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_instr   <= 32'h0;
            skid_fun     <= FUN_NONE;
            skid_illegal <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_valid    <= out_valid_next;
            out_instr    <= out_instr_next;
            out_fun      <= out_fun_next;
            out_illegal  <= out_illegal_next;
            skid_valid   <= skid_valid_next;
            skid_instr   <= skid_instr_next;
            skid_fun     <= skid_fun_next;
            skid_illegal <= skid_illegal_next;
            ready_q      <= !skid_valid_next;
        end
    end

    assign bus.ready_o   = ready_q;
    assign bus.valid_o   = out_valid;
    assign bus.instr_o   = out_instr;
    assign bus.alu_fun_o = out_fun;
    assign bus.illegal_o = out_illegal;

endmodule

// File: tb/tb_otter_alu_decode.sv
// Directed and random-stream bench for otter_alu_decode; expectations come from a hand-encoded vector table.
// Expected illegal handling follows OTTER_ALU_DECODE_ILLEGAL_EN exactly as the design build does.
module tb_otter_alu_decode;

`ifdef OTTER_ALU_DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    localparam int N = 33;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   sb_q [$];

    otter_alu_decode_if bus ();

    otter_alu_decode dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-encoded instructions with their decode; ill=1 marks an illegal encoding.
    logic [31:0] tbl_instr [N] = '{
        32'h003100B3, 32'h40000033, 32'h40005013, 32'h123450B7, 32'h00000063,
        32'h00001033, 32'h00002033, 32'h00003033, 32'h00004033, 32'h00005033,
        32'h00006033, 32'h00007033, 32'hFFF00093, 32'h00101013, 32'h02001013,
        32'h00005013, 32'h60005013, 32'hFE006013, 32'h02000033, 32'h40001033,
        32'h00000017, 32'h0000006F, 32'h00000067, 32'h00002003, 32'h00002023,
        32'h0000000F, 32'h00000073, 32'h0000007F, 32'h00000031, 32'h00002013,
        32'h00004013, 32'h00007013, 32'h00003013
    };
    logic [10:0] tbl_fun [N] = '{
        11'h001, 11'h100, 11'h200, 11'h400, 11'h000,
        11'h002, 11'h004, 11'h008, 11'h010, 11'h020,
        11'h040, 11'h080, 11'h001, 11'h002, 11'h000,
        11'h020, 11'h000, 11'h040, 11'h000, 11'h000,
        11'h001, 11'h001, 11'h001, 11'h001, 11'h001,
        11'h000, 11'h000, 11'h000, 11'h000, 11'h004,
        11'h010, 11'h080, 11'h008
    };
    bit tbl_ill [N] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
        1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0
    };

    function automatic logic [10:0] exp_fun(input int idx);
        if (tbl_ill[idx]) return ILL_EN ? 11'h000 : 11'h001;
        return tbl_fun[idx];
    endfunction

    function automatic logic exp_ill(input int idx);
        return tbl_ill[idx] && ILL_EN;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] instr, input logic ready, input logic flush);
        bus.valid_i = valid;
        bus.instr_i = instr;
        bus.ready_i = ready;
        bus.flush_i = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string tag, input int idx);
        check_output({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        check_output({tag, "_instr"}, bus.instr_o, tbl_instr[idx]);
        check_output({tag, "_fun"}, 32'(bus.alu_fun_o), 32'(exp_fun(idx)));
        check_output({tag, "_ill"}, 32'(bus.illegal_o), 32'(exp_ill(idx)));
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        check_output({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    endtask

    initial begin
        int stream_idx [5] = '{0, 1, 2, 3, 4};
        int idx;
        bit in_fire;
        bit out_fire;
        int exp_idx;
        int drain;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();

        check_idle("reset");
        check_output("reset_fun", 32'(bus.alu_fun_o), 32'd0);
        check_output("reset_instr", bus.instr_o, 32'd0);
        check_output("reset_ill", 32'(bus.illegal_o), 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back stream with execute always ready: one result per cycle, one cycle after acceptance.
        foreach (stream_idx[i]) begin
            apply_stimulus(1'b1, tbl_instr[stream_idx[i]], 1'b1, 1'b0);
            tick();
            check_entry($sformatf("stream%0d", i), stream_idx[i]);
            check_output($sformatf("stream%0d_ready", i), 32'(bus.ready_o), 32'd1);
        end
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_idle("stream_end");

        // Backpressure: A lands in the output register, B in the skid, C waits until ready_o returns.
        apply_stimulus(1'b1, tbl_instr[8], 1'b0, 1'b0);
        tick();
        check_entry("bp_a", 8);
        check_output("bp_ready1", 32'(bus.ready_o), 32'd1);
        apply_stimulus(1'b1, tbl_instr[11], 1'b0, 1'b0);
        tick();
        check_entry("bp_hold1", 8);
        check_output("bp_ready2", 32'(bus.ready_o), 32'd0);
        apply_stimulus(1'b1, tbl_instr[6], 1'b0, 1'b0);
        tick();
        check_entry("bp_hold2", 8);
        check_output("bp_ready3", 32'(bus.ready_o), 32'd0);
        apply_stimulus(1'b1, tbl_instr[6], 1'b1, 1'b0);
        tick();
        check_entry("bp_b", 11);
        check_output("bp_ready4", 32'(bus.ready_o), 32'd1);
        tick();
        check_entry("bp_c", 6);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_idle("bp_end");

        // Flush with both entries full and a new instruction offered in the same cycle.
        apply_stimulus(1'b1, tbl_instr[9], 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, tbl_instr[10], 1'b0, 1'b0);
        tick();
        check_output("fl_full", 32'(bus.ready_o), 32'd0);
        apply_stimulus(1'b1, tbl_instr[3], 1'b0, 1'b1);
        tick();
        check_idle("flush");
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_idle("flush_after1");
        tick();
        check_idle("flush_after2");

        // OP with funct7=0000001 and a non-RV32 opcode.
        apply_stimulus(1'b1, tbl_instr[18], 1'b1, 1'b0);
        tick();
        check_entry("ill_op", 18);
        apply_stimulus(1'b1, tbl_instr[28], 1'b1, 1'b0);
        tick();
        check_entry("ill_low", 28);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        // Reset while both entries are occupied and a further instruction is offered.
        apply_stimulus(1'b1, tbl_instr[5], 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, tbl_instr[7], 1'b0, 1'b0);
        tick();
        check_output("rst_pre_valid", 32'(bus.valid_o), 32'd1);
        check_output("rst_pre_ready", 32'(bus.ready_o), 32'd0);
        rst = 1'b1;
        apply_stimulus(1'b1, tbl_instr[1], 1'b1, 1'b1);
        tick();
        check_idle("rst_mid");
        check_output("rst_mid_fun", 32'(bus.alu_fun_o), 32'd0);
        check_output("rst_mid_instr", bus.instr_o, 32'd0);
        check_output("rst_mid_ill", 32'(bus.illegal_o), 32'd0);
        rst = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_idle("rst_after");

        // Random handshake stream against a reference queue of accepted table indices.
        for (int cyc = 0; cyc < 400; cyc++) begin
            idx = int'($urandom_range(0, N - 1));
            apply_stimulus($urandom_range(0, 9) < 7, tbl_instr[idx], $urandom_range(0, 9) < 6, 1'b0);
            #1;
            in_fire  = bus.valid_i && bus.ready_o;
            out_fire = bus.valid_o && bus.ready_i;
            check_output("rnd_onehot", 32'($onehot0(bus.alu_fun_o)), 32'd1);
            if (out_fire) begin
                if (sb_q.size() == 0) begin
                    check_output("rnd_spurious", 32'(bus.valid_o), 32'd0);
                end else begin
                    exp_idx = sb_q.pop_front();
                    check_output("rnd_instr", bus.instr_o, tbl_instr[exp_idx]);
                    check_output("rnd_fun", 32'(bus.alu_fun_o), 32'(exp_fun(exp_idx)));
                    check_output("rnd_ill", 32'(bus.illegal_o), 32'(exp_ill(exp_idx)));
                end
            end
            if (in_fire) sb_q.push_back(idx);
            @(posedge clk);
            #1;
        end

        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        drain = 0;
        while (sb_q.size() > 0 && drain < 20) begin
            #1;
            if (bus.valid_o) begin
                exp_idx = sb_q.pop_front();
                check_output("drain_instr", bus.instr_o, tbl_instr[exp_idx]);
                check_output("drain_fun", 32'(bus.alu_fun_o), 32'(exp_fun(exp_idx)));
            end
            tick();
            drain++;
        end
        check_output("drain_empty", 32'(sb_q.size()), 32'd0);
        #1;
        check_idle("drain_end");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/otter_alu_decode.md
OTTER_ALU_DECODE -- requirements
Module: otter_alu_decode

Interface
REQ-001 The block SHALL expose the following ports:
- clk_i  input  1  sole clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- instr_i  input  32  RV32I instruction from fetch.
- valid_i  input  1  instr_i is valid.
- ready_o  output  1  block can accept instr_i this cycle.
- flush_i  input  1  discard all held and incoming instructions.
- alu_fun_o  output  11  one-hot ALU control for the execute-stage ALU, or all-zero.
- instr_o  output  32  instruction paired with alu_fun_o.
- illegal_o  output  1  paired instruction has an illegal encoding.
- valid_o  output  1  outputs are valid.
- ready_i  input  1  execute stage accepts outputs this cycle.

REQ-002 The alu_fun_o bit map SHALL be fixed as follows:
- 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL
- 6 OR, 7 AND, 8 SUB, 9 SRA, 10 pass op1 (LUI)

Function
REQ-003 alu_fun_o SHALL have at most one bit set at all times; all-zero means no ALU operation.
REQ-004 Decoding of OP (0110011) SHALL use funct3 together with funct7:
- funct7=0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- funct7=0100000: 000 SUB, 101 SRA.
- Any other funct7/funct3 combination is illegal.
REQ-005 Decoding of OP-IMM (0010011) SHALL follow the OP funct3 map with these differences:
- 000 is always ADD.
- 001 requires funct7=0000000.
- 101 with funct7=0000000 decodes to SRL; with 0100000 to SRA; any other funct7 is illegal.
REQ-006 LUI (0110111) SHALL decode to bit 10.
REQ-007 AUIPC, JAL, JALR, LOAD and STORE SHALL decode to ADD.
REQ-008 BRANCH, MISC-MEM and SYSTEM SHALL decode to all-zero and are legal.
REQ-009 Any other opcode, or instr_i[1:0]!=11, SHALL be illegal.
REQ-010 Illegal instructions SHALL be handled per REQ-022/REQ-023.
REQ-011 A transfer in SHALL occur when valid_i && ready_o; a transfer out SHALL occur when valid_o && ready_i.
REQ-012 Latency SHALL be one cycle: an instruction accepted at edge N appears on the outputs with valid_o=1 after edge N when the output register is empty or draining.
REQ-013 Buffering SHALL be an output register plus one skid entry (two entries in total).
REQ-014 ready_o SHALL be a register output equal to "skid entry empty"; it SHALL NOT depend combinationally on ready_i.
REQ-015 When ready_i=0 with the output register full and an instruction is accepted, that instruction SHALL enter the skid entry and ready_o SHALL drop the next cycle.
REQ-016 When the skid entry is full and the output transfers, the skid contents SHALL move to the output register in the same edge, and ready_o SHALL rise the next cycle.
REQ-017 Instructions SHALL leave in strict acceptance order, with no duplication and no loss.
REQ-018 While valid_o=1 and ready_i=0, alu_fun_o, instr_o and illegal_o SHALL hold stable.
REQ-019 When flush_i=1 at an edge, both entries SHALL be emptied and any same-cycle input SHALL be dropped; after that edge valid_o=0 and ready_o=1.
REQ-020 flush_i SHALL take priority over every other event in the same cycle.

Reset
REQ-021 When rst_i=1 at an edge, the block SHALL clear to the following state, ignoring valid_i and flush_i that cycle:
- valid_o=0, alu_fun_o=0, instr_o=0, illegal_o=0.
- Skid entry empty, ready_o=1.
- Reset mid-transfer discards all held instructions.

Configuration
REQ-022 With macro OTTER_ALU_DECODE_ILLEGAL_EN defined, an illegal instruction SHALL produce illegal_o=1 with alu_fun_o=0.
REQ-023 Without OTTER_ALU_DECODE_ILLEGAL_EN, illegal_o SHALL be constant 0, and illegal encodings SHALL decode to ADD (bit 0) with no other behavioural change.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Stream with ready_i=1: ADD, SUB (0x40000033), SRAI (0x40005013), LUI, BEQ -> alu_fun_o = 0x001, 0x100, 0x200, 0x400, 0x000 on consecutive cycles, each one cycle after acceptance.
- Backpressure: ready_i=0 for 3 cycles with valid_i=1 continuous -> second instruction held in skid, ready_o=0 from the cycle after, and order preserved when ready_i returns to 1.
- Flush with both entries full and valid_i=1 -> next cycle valid_o=0, ready_o=1, and the flushed instructions never appear.
- OP with funct7=0000001 (0x02000033): with the macro, illegal_o=1 and alu_fun_o=0; without the macro, alu_fun_o=0x001 and illegal_o=0.
- rst_i asserted while valid_o=1 and the skid is full -> next cycle all outputs zero and ready_o=1.
- Random constrained stream -> alu_fun_o is one-hot or zero on every cycle and the output order matches a reference queue.
